// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - PWM duty fade controller with step divider and optional gamma map
// Optional square-law output mapping enabled by defining PWM_FADE_GAMMA_EN.
module pwm_fade_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [DIV_W-1:0] step_div,
  input  logic [7:0]       step_size,
  output logic [7:0]       duty,
  output logic             pwm_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       level, level_nxt;
  logic [7:0]       tgt, tgt_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;

  logic [8:0] step9, lvl9, tgt9, diff_up, diff_dn, sum9, sub9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      level  <= 8'd0;
      tgt    <= 8'd0;
      cnt    <= '0;
      pwm_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      tgt    <= tgt_nxt;
      cnt    <= cnt_nxt;
      pwm_en <= en;
    end
  end

  // 9-bit arithmetic keeps the overshoot/underflow comparisons free of wrap
  always_comb begin
    step9   = (step_size == 8'd0) ? 9'd1 : {1'b0, step_size};
    lvl9    = {1'b0, level};
    tgt9    = {1'b0, tgt};
    diff_up = tgt9 - lvl9;
    diff_dn = lvl9 - tgt9;
    sum9    = lvl9 + step9;
    sub9    = lvl9 - step9;
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    tgt_nxt   = tgt;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (en && target_valid) begin
          tgt_nxt   = target;
          cnt_nxt   = '0;
          state_nxt = (target != level) ? RAMP : DONE;
        end
      end
      RAMP: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (cnt == step_div) begin
          cnt_nxt = '0;
          if (tgt9 >= lvl9) begin
            if (diff_up <= step9) begin
              level_nxt = tgt;
              state_nxt = DONE;
            end else begin
              level_nxt = sum9[7:0];
            end
          end else begin
            if (diff_dn <= step9) begin
              level_nxt = tgt;
              state_nxt = DONE;
            end else begin
              level_nxt = sub9[7:0];
            end
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign target_ready = rst_n && en && (state == IDLE);
  assign busy         = (state == RAMP);
  assign done         = (state == DONE) && en;

`ifdef PWM_FADE_GAMMA_EN
  logic [15:0] level_sq;
  logic [16:0] level_sq_rnd;

  always_comb begin
    level_sq     = 16'(level) * 16'(level);
    level_sq_rnd = {1'b0, level_sq} + 17'd255;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty <= 8'd0;
    else        duty <= level_sq_rnd[15:8];
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty <= 8'd0;
    else        duty <= level;
  end
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - self-checking bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  target;
  logic        target_valid;
  logic        target_ready;
  logic [15:0] step_div;
  logic [7:0]  step_size;
  logic [7:0]  duty;
  logic        pwm_en;
  logic        busy;
  logic        done;

  pwm_fade_ctrl #(.DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .step_div     (step_div),
    .step_size    (step_size),
    .duty         (duty),
    .pwm_en       (pwm_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int div;
    int size;
    int tgt;
    int nsteps;
  } vec_t;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   model_level = 0;
  ev_t  sb[$];
  vec_t vecs[8];

  function automatic int gmap(int l);
`ifdef PWM_FADE_GAMMA_EN
    return (l * l + 255) >> 8;
`else
    return l;
`endif
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(int div, int size, int tgt, int nsteps);
    int lvl, stp, k, dly;
    ev_t e;
    @(negedge clk);
    step_div     = 16'(div);
    step_size    = 8'(size);
    target       = 8'(tgt);
    target_valid = 1'b1;
    check("ready_before_accept", int'(target_ready), 1);
    lvl = model_level;
    stp = (size == 0) ? 1 : size;
    k   = 0;
    while (lvl != tgt) begin
      if (tgt > lvl) lvl = (tgt - lvl <= stp) ? tgt : lvl + stp;
      else           lvl = (lvl - tgt <= stp) ? tgt : lvl - stp;
      k++;
      sb.push_back('{k * (div + 1) + 1, gmap(lvl)});
    end
    model_level = tgt;
    @(posedge clk);
    @(negedge clk);
    target_valid = 1'b0;
    dly = (nsteps == 0) ? 0 : nsteps * (div + 1);
    for (int m = 0; m <= dly + 2; m++) begin
      check($sformatf("done_t%0d_c%0d", tgt, m), int'(done), (m == dly) ? 1 : 0);
      check($sformatf("busy_t%0d_c%0d", tgt, m), int'(busy), (nsteps > 0 && m < dly) ? 1 : 0);
      if (sb.size() > 0 && sb[0].cyc == m) begin
        e = sb.pop_front();
        check($sformatf("duty_t%0d_c%0d", tgt, m), int'(duty), e.val);
      end
      if (m < dly + 2) @(negedge clk);
    end
    check($sformatf("sb_drained_t%0d", tgt), sb.size(), 0);
    check($sformatf("duty_final_t%0d", tgt), int'(duty), gmap(tgt));
    check($sformatf("ready_after_t%0d", tgt), int'(target_ready), 1);
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{3, 10, 25, 3};
    vecs[1] = '{0, 100, 200, 2};
    vecs[2] = '{0, 100, 0, 2};
    vecs[3] = '{1, 0, 3, 3};
    vecs[4] = '{2, 255, 255, 1};
    vecs[5] = '{0, 200, 255, 0};
    vecs[6] = '{0, 7, 240, 3};
    vecs[7] = '{0, 255, 128, 1};

    rst_n        = 1'b0;
    en           = 1'b1;
    target       = 8'd0;
    target_valid = 1'b0;
    step_div     = 16'd0;
    step_size    = 8'd1;
    repeat (2) @(negedge clk);
    check("rst_duty", int'(duty), 0);
    check("rst_pwm_en", int'(pwm_en), 0);
    check("rst_ready", int'(target_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    #1;
    check("rel_pwm_en_before_edge", int'(pwm_en), 0);
    @(negedge clk);
    check("rel_pwm_en", int'(pwm_en), 1);
    check("rel_ready", int'(target_ready), 1);
    check("rel_duty", int'(duty), 0);
    check("rel_busy", int'(busy), 0);

    foreach (vecs[i]) run_vec(vecs[i].div, vecs[i].size, vecs[i].tgt, vecs[i].nsteps);

    // mid-ramp: ignored request, then enable drop
    @(negedge clk);
    step_div = 16'd3; step_size = 8'd10; target = 8'd200; target_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    target_valid = 1'b0;
    @(negedge clk);
    target = 8'd50; target_valid = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      check($sformatf("mid_ready_c%0d", m), int'(target_ready), 0);
      @(negedge clk);
    end
    check("mid_duty_step", int'(duty), gmap(138));
    en = 1'b0; target_valid = 1'b0;
    @(negedge clk);
    check("abort_pwm_en", int'(pwm_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(target_ready), 0);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("abort_done_c%0d", m), int'(done), 0);
      check($sformatf("abort_duty_c%0d", m), int'(duty), gmap(138));
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    check("reen_ready", int'(target_ready), 1);
    model_level = 138;
    run_vec(0, 5, 138, 0);

    // mid-ramp asynchronous reset
    @(negedge clk);
    step_div = 16'd3; step_size = 8'd10; target = 8'd100; target_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    target_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_duty", int'(duty), gmap(128));
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_duty", int'(duty), 0);
    check("arst_pwm_en", int'(pwm_en), 0);
    check("arst_ready", int'(target_ready), 0);
    check("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      check($sformatf("post_rst_busy_c%0d", m), int'(busy), 0);
      check($sformatf("post_rst_duty_c%0d", m), int'(duty), 0);
    end
    model_level = 0;
    run_vec(0, 0, 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
